// File: rtl/seven_segment_capture.sv
// Seven-segment bus monitor: samples scanned digit-select/segment lines, decodes stable patterns to nibbles
// and assembles DIGITS-wide frames. Define SEVEN_SEG_ACTIVE_LOW_EN for common-anode (active-low) inputs.
module seven_segment_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            abcdefgh,
  input  logic [DIGITS-1:0]     digit,
  output logic [4*DIGITS-1:0]   frame_value,
  output logic [DIGITS-1:0]     frame_dots,
  output logic [DIGITS-1:0]     frame_err,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  overrun,
  output logic                  state_dbg
);

  // Handshake: a frame transfers on any clk edge where frame_valid & frame_ready; while frame_valid
  // is high without a transfer, frame_value/dots/err are held unchanged.

  localparam int W  = DIGITS + 8;
  localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  typedef enum logic {COLLECT = 1'b0, COMMIT = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [W-1:0]          in_eff;
  logic [W-1:0]          sample_q, sample_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  hit_q, hit_d;
  logic [DIGITS-1:0]     filled_q, filled_d;
  logic [4*DIGITS-1:0]   shadow_val_q, shadow_val_d;
  logic [DIGITS-1:0]     shadow_dot_q, shadow_dot_d;
  logic [DIGITS-1:0]     shadow_err_q, shadow_err_d;
  logic [4*DIGITS-1:0]   frame_value_q, frame_value_d;
  logic [DIGITS-1:0]     frame_dots_q, frame_dots_d;
  logic [DIGITS-1:0]     frame_err_q, frame_err_d;
  logic                  frame_valid_q, frame_valid_d;
  logic                  overrun_q, overrun_d;

  logic [DIGITS-1:0]     dsel;
  logic [7:0]            seg;
  logic                  onehot;
  logic                  cap;
  logic [DIGITS-1:0]     cap_mask;
  logic [3:0]            dec_nib;
  logic                  dec_err;
  logic                  hs;
  logic                  load;

`ifdef SEVEN_SEG_ACTIVE_LOW_EN
  assign in_eff = ~{digit, abcdefgh};
`else
  assign in_eff = {digit, abcdefgh};
`endif

  // The dot (h) is carried separately, so it is forced low before matching.
  always_comb begin
    dec_nib = 4'h0;
    dec_err = 1'b0;
    case ({seg[7:1], 1'b0})
      8'hFC: dec_nib = 4'h0;
      8'h60: dec_nib = 4'h1;
      8'hDA: dec_nib = 4'h2;
      8'hF2: dec_nib = 4'h3;
      8'h66: dec_nib = 4'h4;
      8'hB6: dec_nib = 4'h5;
      8'hBE: dec_nib = 4'h6;
      8'hE0: dec_nib = 4'h7;
      8'hFE: dec_nib = 4'h8;
      8'hF6: dec_nib = 4'h9;
      8'hEE: dec_nib = 4'hA;
      8'h3E: dec_nib = 4'hB;
      8'h9C: dec_nib = 4'hC;
      8'h7A: dec_nib = 4'hD;
      8'h9E: dec_nib = 4'hE;
      8'h8E: dec_nib = 4'hF;
      default: begin
        dec_nib = 4'h0;
        dec_err = 1'b1;
      end
    endcase
  end

  always_comb begin
    seg    = sample_q[7:0];
    dsel   = sample_q[W-1:8];
    onehot = (dsel != '0) && ((dsel & (dsel - 1'b1)) == '0);

    sample_d = in_eff;
    if (in_eff != sample_q)   cnt_d = '0;
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else                       cnt_d = cnt_q + CW'(1);

    // hit_q remembers the counter was already saturated, giving one capture per stable run.
    hit_d    = (cnt_q == CNT_MAX);
    cap      = (cnt_q == CNT_MAX) && !hit_q && onehot;
    cap_mask = cap ? dsel : '0;

    shadow_val_d = shadow_val_q;
    shadow_dot_d = shadow_dot_q;
    shadow_err_d = shadow_err_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (cap_mask[i]) begin
        shadow_val_d[4*i +: 4] = dec_nib;
        shadow_dot_d[i]        = seg[0];
        shadow_err_d[i]        = dec_err;
      end
    end

    filled_d = ((state_q == COMMIT) ? '0 : filled_q) | cap_mask;

    state_d = state_q;
    case (state_q)
      COLLECT: if (filled_d == '1) state_d = COMMIT;
      COMMIT:  state_d = COLLECT;
      default: state_d = COLLECT;
    endcase

    hs   = frame_valid_q & frame_ready;
    load = (state_q == COMMIT) && (!frame_valid_q || hs);

    frame_value_d = frame_value_q;
    frame_dots_d  = frame_dots_q;
    frame_err_d   = frame_err_q;
    frame_valid_d = frame_valid_q;
    if (load) begin
      frame_value_d = shadow_val_q;
      frame_dots_d  = shadow_dot_q;
      frame_err_d   = shadow_err_q;
      frame_valid_d = 1'b1;
    end else if (hs) begin
      frame_valid_d = 1'b0;
    end
    overrun_d = overrun_q | ((state_q == COMMIT) && frame_valid_q && !hs);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= COLLECT;
      sample_q      <= '0;
      cnt_q         <= '0;
      hit_q         <= 1'b0;
      filled_q      <= '0;
      shadow_val_q  <= '0;
      shadow_dot_q  <= '0;
      shadow_err_q  <= '0;
      frame_value_q <= '0;
      frame_dots_q  <= '0;
      frame_err_q   <= '0;
      frame_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sample_q      <= sample_d;
      cnt_q         <= cnt_d;
      hit_q         <= hit_d;
      filled_q      <= filled_d;
      shadow_val_q  <= shadow_val_d;
      shadow_dot_q  <= shadow_dot_d;
      shadow_err_q  <= shadow_err_d;
      frame_value_q <= frame_value_d;
      frame_dots_q  <= frame_dots_d;
      frame_err_q   <= frame_err_d;
      frame_valid_q <= frame_valid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign frame_value = frame_value_q;
  assign frame_dots  = frame_dots_q;
  assign frame_err   = frame_err_q;
  assign frame_valid = frame_valid_q;
  assign overrun     = overrun_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed bench for seven_segment_capture (DIGITS=4, STABLE_CYCLES=4); stimulus is inverted
// automatically when SEVEN_SEG_ACTIVE_LOW_EN is defined so expectations stay identical.
module tb_seven_segment_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  abcdefgh;
  logic [3:0]  digit;
  logic [15:0] frame_value;
  logic [3:0]  frame_dots;
  logic [3:0]  frame_err;
  logic        frame_valid;
  logic        frame_ready;
  logic        overrun;
  logic        state_dbg;

  int checks   = 0;
  int failures = 0;

  seven_segment_capture #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .abcdefgh    (abcdefgh),
    .digit       (digit),
    .frame_value (frame_value),
    .frame_dots  (frame_dots),
    .frame_err   (frame_err),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .overrun     (overrun),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // drivers
  task automatic set_in(input logic [3:0] d, input logic [7:0] s);
`ifdef SEVEN_SEG_ACTIVE_LOW_EN
    digit    = ~d;
    abcdefgh = ~s;
`else
    digit    = d;
    abcdefgh = s;
`endif
  endtask

  task automatic drive(input logic [3:0] d, input logic [7:0] s, input int n);
    set_in(d, s);
    step(n);
  endtask

  // checker
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    frame_ready = 1'b1;
    set_in(4'b0000, 8'h00);
    step(3);
    chk("rst_valid",   frame_valid, 0);
    chk("rst_value",   frame_value, 0);
    chk("rst_dots",    frame_dots, 0);
    chk("rst_err",     frame_err, 0);
    chk("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    drive(4'b0000, 8'h00, 3);

    // basic scan; frame appears exactly one clk after the last slot write
    drive(4'b0001, 8'hFC, 6);
    drive(4'b0010, 8'h60, 6);
    drive(4'b0100, 8'hDA, 6);
    drive(4'b1000, 8'hF3, 5);
    chk("t1_valid_early", frame_valid, 0);
    step(1);
    chk("t1_valid", frame_valid, 1);
    chk("t1_value", frame_value, 32'h3210);
    chk("t1_dots",  frame_dots, 4'b1000);
    chk("t1_err",   frame_err, 0);
    step(1);
    chk("t1_handshake_drop", frame_valid, 0);
    drive(4'b0000, 8'h00, 4);

    // short (3 clk) run on digit 0 is not captured
    drive(4'b0001, 8'h60, 3);
    drive(4'b0010, 8'hDA, 6);
    drive(4'b0100, 8'hF2, 6);
    drive(4'b1000, 8'h66, 6);
    drive(4'b0000, 8'h00, 4);
    chk("t2_short_run_no_frame", frame_valid, 0);
    drive(4'b0001, 8'hFC, 5);
    chk("t2_valid_early", frame_valid, 0);
    step(1);
    chk("t2_valid", frame_valid, 1);
    chk("t2_value", frame_value, 32'h4320);
    chk("t2_err",   frame_err, 0);
    drive(4'b0000, 8'h00, 4);
    chk("t2_drop", frame_valid, 0);

    // multi-hot and all-zero selects never fill a slot
    drive(4'b0011, 8'hFE, 20);
    drive(4'b0000, 8'hFE, 20);
    chk("t3_no_frame", frame_valid, 0);

    // undecodable pattern on digit 2; slot 0 must still be empty from above
    drive(4'b0010, 8'h7A, 6);
    drive(4'b0100, 8'h02, 6);
    drive(4'b1000, 8'h8E, 6);
    drive(4'b0000, 8'h00, 4);
    chk("t3_slot0_empty", frame_valid, 0);
    drive(4'b0001, 8'h9C, 6);
    chk("t4_valid", frame_valid, 1);
    chk("t4_value", frame_value, 32'hF0DC);
    chk("t4_err",   frame_err, 4'b0100);
    chk("t4_dots",  frame_dots, 0);
    drive(4'b0000, 8'h00, 4);

    // back-pressure: second frame dropped, overrun sticky
    frame_ready = 1'b0;
    drive(4'b0001, 8'hEE, 6);
    drive(4'b0010, 8'h3F, 6);
    drive(4'b0100, 8'h9E, 6);
    drive(4'b1000, 8'hE0, 6);
    chk("t5_valid1",   frame_valid, 1);
    chk("t5_value1",   frame_value, 32'h7EBA);
    chk("t5_dots1",    frame_dots, 4'b0010);
    chk("t5_overrun0", overrun, 0);
    drive(4'b0001, 8'hFE, 6);
    drive(4'b0010, 8'hF6, 6);
    drive(4'b0100, 8'hFC, 6);
    drive(4'b1000, 8'h61, 6);
    chk("t5_valid_held",   frame_valid, 1);
    chk("t5_value_held",   frame_value, 32'h7EBA);
    chk("t5_dots_held",    frame_dots, 4'b0010);
    chk("t5_err_held",     frame_err, 0);
    chk("t5_overrun_set",  overrun, 1);
    frame_ready = 1'b1;
    step(1);
    chk("t5_valid_drop",   frame_valid, 0);
    chk("t5_overrun_kept", overrun, 1);
    drive(4'b0000, 8'h00, 4);

    // async reset mid-scan discards the partial frame
    drive(4'b0001, 8'hFC, 6);
    drive(4'b0010, 8'h60, 6);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_value",   frame_value, 0);
    chk("t6_rst_overrun", overrun, 0);
    chk("t6_rst_valid",   frame_valid, 0);
    set_in(4'b0000, 8'h00);
    step(2);
    rst_n = 1'b1;
    drive(4'b0000, 8'h00, 3);
    drive(4'b0100, 8'hE0, 6);
    drive(4'b1000, 8'hFE, 6);
    drive(4'b0000, 8'h00, 4);
    chk("t6_partial_discarded", frame_valid, 0);
    drive(4'b0001, 8'hB6, 6);
    drive(4'b0010, 8'hBE, 6);
    chk("t6_valid",   frame_valid, 1);
    chk("t6_value",   frame_value, 32'h8765);
    chk("t6_dots",    frame_dots, 0);
    chk("t6_err",     frame_err, 0);
    chk("t6_overrun", overrun, 0);
    drive(4'b0000, 8'h00, 4);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
